// File: rtl/platform_manager_pkg.sv
// Shared game constants for the platform manager: geometry, scan FSM encoding,
// LFSR seed/taps and the power-up block placement table.
package platform_manager_pkg;

  localparam int PM_SCREEN_WIDTH  = 400;
  localparam int PM_SCREEN_HEIGHT = 700;
  localparam int PM_BLOCK_WIDTH   = 40;
  localparam int PM_BLOCK_HEIGHT  = 5;
  localparam int PM_NUM_BLOCKS    = 8;
  localparam int PM_SCROLL_LINE   = 350;
  localparam int PM_IDX_W         = $clog2(PM_NUM_BLOCKS);

  localparam logic [15:0] PM_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] PM_LFSR_TAPS = 16'hB400;

  // Reset placement: x steps 120 px around the 360 px spawnable range, y 87 px apart.
  localparam int PM_X_RANGE  = PM_SCREEN_WIDTH - PM_BLOCK_WIDTH;
  localparam int PM_RST_X0   = 180;
  localparam int PM_RST_DX   = 120;
  localparam int PM_RST_DY   = 87;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SCROLL,
    ST_RESPAWN
  } pm_state_e;

  function automatic logic [31:0] pm_rst_x(input int i);
    return 32'((PM_RST_X0 + PM_RST_DX * i) % PM_X_RANGE);
  endfunction

  function automatic logic [31:0] pm_rst_y(input int i);
    return 32'(PM_RST_DY * i);
  endfunction

endpackage

// File: rtl/platform_manager_if.sv
// Game-side bus of the platform manager: physics tick, doodle state, collision
// result, scroll pulse and render read port.
interface platform_manager_if
  import platform_manager_pkg::*;
  ();
  logic                physicsUpdate;
  logic [31:0]         doodleX;
  logic [31:0]         doodleY;
  logic                falling;
  logic                hasCollide;
  logic                scroll;
  logic [PM_IDX_W-1:0] rdIdx;
  logic [31:0]         rdX;
  logic [31:0]         rdY;
  logic                busy;
  logic                tickMissed;

  modport master (
    output physicsUpdate, doodleX, doodleY, falling, rdIdx,
    input  hasCollide, scroll, rdX, rdY, busy, tickMissed
  );

  modport slave (
    input  physicsUpdate, doodleX, doodleY, falling, rdIdx,
    output hasCollide, scroll, rdX, rdY, busy, tickMissed
  );
endinterface

// File: rtl/platform_lfsr.sv
// Free-running 16-bit Galois LFSR folded into a block left-edge x in [0, X_RANGE).
module platform_lfsr
  import platform_manager_pkg::*;
#(
  parameter int X_RANGE = PM_X_RANGE
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] x_o
);
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] raw;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? PM_LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= PM_LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  // 9 bits reach 511; one subtraction folds 360..511 back into range.
  assign raw = {23'd0, lfsr_q[8:0]};
  assign x_o = (raw >= 32'(X_RANGE)) ? raw - 32'(X_RANGE) : raw;

endmodule

// File: rtl/platform_manager.sv
// Platform manager: per-tick collision scan over the block table, then optional
// one-pixel world scroll and respawn of blocks that fell off the bottom.
module platform_manager
  import platform_manager_pkg::*;
#(
  parameter int SCREEN_WIDTH  = PM_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = PM_SCREEN_HEIGHT,
  parameter int BLOCK_WIDTH   = PM_BLOCK_WIDTH,
  parameter int BLOCK_HEIGHT  = PM_BLOCK_HEIGHT,
  parameter int NUM_BLOCKS    = PM_NUM_BLOCKS,
  parameter int SCROLL_LINE   = PM_SCROLL_LINE
) (
  input  logic               clk,
  input  logic               reset,
  platform_manager_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);

  if (BLOCK_HEIGHT < 1 || BLOCK_WIDTH >= SCREEN_WIDTH) begin : g_bad_cfg
    $error("platform_manager: invalid block geometry");
  end

  pm_state_e                    state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         pu_q, pu_d;
  logic                         flag_q, flag_d;
  logic                         collide_q, collide_d;
  logic                         missed_q, missed_d;
  logic [NUM_BLOCKS-1:0][31:0]  x_q, x_d, y_q, y_d;
  logic [31:0]                  spawn_x;
  logic                         tick_edge, hit, last;

  platform_lfsr #(.X_RANGE(SCREEN_WIDTH - BLOCK_WIDTH)) u_lfsr (
    .clk   (clk),
    .rst_n (reset),
    .x_o   (spawn_x)
  );

  assign tick_edge = bus.physicsUpdate & ~pu_q;
  assign last      = (idx_q == IDX_W'(NUM_BLOCKS - 1));
  // Inputs are taken live each SCAN cycle, so only the block under idx_q sees them.
  assign hit = bus.falling
             && (bus.doodleX >= x_q[idx_q])
             && (bus.doodleX <  x_q[idx_q] + 32'(BLOCK_WIDTH))
             && (bus.doodleY == y_q[idx_q]);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pu_d      = bus.physicsUpdate;
    flag_d    = flag_q;
    collide_d = collide_q;
    missed_d  = missed_q;
    x_d       = x_q;
    y_d       = y_q;
    if (tick_edge && state_q != ST_IDLE) missed_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (tick_edge) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          flag_d  = 1'b0;
        end
      end
      ST_SCAN: begin
        flag_d = flag_q | hit;
        idx_d  = idx_q + IDX_W'(1);
        if (last) begin
          collide_d = flag_q | hit;
          idx_d     = '0;
          state_d   = (bus.doodleY > 32'(SCROLL_LINE)) ? ST_SCROLL : ST_IDLE;
        end
      end
      ST_SCROLL: begin
        for (int i = 0; i < NUM_BLOCKS; i++)
          y_d[i] = (y_q[i] != 32'd0) ? y_q[i] - 32'd1 : 32'd0;
        idx_d   = '0;
        state_d = ST_RESPAWN;
      end
      ST_RESPAWN: begin
        if (y_q[idx_q] == 32'd0) begin
          y_d[idx_q] = 32'(SCREEN_HEIGHT - 1);
          x_d[idx_q] = spawn_x;
        end
        idx_d = idx_q + IDX_W'(1);
        if (last) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pu_q      <= 1'b0;
      flag_q    <= 1'b0;
      collide_q <= 1'b0;
      missed_q  <= 1'b0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        x_q[i] <= pm_rst_x(i);
        y_q[i] <= pm_rst_y(i);
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pu_q      <= pu_d;
      flag_q    <= flag_d;
      collide_q <= collide_d;
      missed_q  <= missed_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign bus.hasCollide = collide_q;
  assign bus.tickMissed = missed_q;
  assign bus.scroll     = (state_q == ST_SCROLL);
  assign bus.busy       = (state_q != ST_IDLE) | tick_edge;
  assign bus.rdX        = (int'(bus.rdIdx) < NUM_BLOCKS) ? x_q[bus.rdIdx] : 32'd0;
  assign bus.rdY        = (int'(bus.rdIdx) < NUM_BLOCKS) ? y_q[bus.rdIdx] : 32'd0;

endmodule

// File: tb/tb_platform_manager.sv
// Directed bench for platform_manager: collision scan, scroll/respawn, dropped
// ticks and reset recovery, checked against hand-computed values.
module tb_platform_manager;
  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  platform_manager_if bus ();

  platform_manager dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic read_blk(input int idx, output logic [31:0] x, output logic [31:0] y);
    bus.rdIdx = 3'(idx);
    #1;
    x = bus.rdX;
    y = bus.rdY;
  endtask

  // One physics tick; fall_k / edge2_k pick the busy-cycle at which falling is
  // changed or a second tick edge is raised (-1 = never).
  task automatic run_tick(input int fall_k, input logic fall_v, input int edge2_k,
                          output int busy_n, output int scroll_n, output logic done);
    @(posedge clk);
    #1 bus.physicsUpdate = 1'b1;
    busy_n = 0; scroll_n = 0; done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
      busy_n++;
      if (bus.scroll) scroll_n++;
      if (k == 1) bus.physicsUpdate = 1'b0;
      if (k == edge2_k) bus.physicsUpdate = 1'b1;
      if (k == fall_k) bus.falling = fall_v;
    end
    bus.physicsUpdate = 1'b0;
  endtask

  task automatic collide_case(input string tag, input int dx, input int dy,
                              input logic fall, input logic exp);
    int bn, sn;
    logic dn;
    bus.doodleX = 32'(dx);
    bus.doodleY = 32'(dy);
    bus.falling = fall;
    run_tick(-1, 1'b0, -1, bn, sn, dn);
    chk({tag, "_done"}, 32'(dn), 32'd1);
    chk(tag, 32'(bus.hasCollide), 32'(exp));
  endtask

  initial begin
    int bn, sn, scroll_tot, bad;
    logic dn;
    logic [31:0] rx, ry;

    reset = 1'b0;
    bus.physicsUpdate = 1'b0;
    bus.doodleX = 32'd200;
    bus.doodleY = 32'd0;
    bus.falling = 1'b1;
    bus.rdIdx   = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_collide", 32'(bus.hasCollide), 32'd0);
    chk("rst_missed", 32'(bus.tickMissed), 32'd0);
    chk("rst_scroll", 32'(bus.scroll), 32'd0);
    read_blk(0, rx, ry); chk("rst_b0_x", rx, 32'd180); chk("rst_b0_y", ry, 32'd0);
    read_blk(2, rx, ry); chk("rst_b2_x", rx, 32'd60);  chk("rst_b2_y", ry, 32'd174);
    read_blk(7, rx, ry); chk("rst_b7_x", rx, 32'd300); chk("rst_b7_y", ry, 32'd609);

    @(posedge clk);
    #1 reset = 1'b1;

    // Doodle standing on block 0 at spawn: 1 detect + 8 scan cycles, no scroll.
    run_tick(-1, 1'b0, -1, bn, sn, dn);
    chk("spawn_done", 32'(dn), 32'd1);
    chk("spawn_busy_cycles", 32'(bn), 32'd9);
    chk("spawn_scroll", 32'(sn), 32'd0);
    chk("spawn_collide", 32'(bus.hasCollide), 32'd1);

    collide_case("b1_x_miss", 221, 87, 1'b1, 1'b0);
    collide_case("b1_hit", 310, 87, 1'b1, 1'b1);
    collide_case("not_falling", 200, 0, 1'b0, 1'b0);
    collide_case("b0_left_edge", 180, 0, 1'b1, 1'b1);
    collide_case("b0_right_excl", 220, 0, 1'b1, 1'b0);
    collide_case("b0_right_incl", 219, 0, 1'b1, 1'b1);
    collide_case("b0_left_out", 179, 0, 1'b1, 1'b0);
    collide_case("y_off_by_one", 200, 1, 1'b1, 1'b0);

    // falling changed just before block 1 is visited.
    bus.doodleX = 32'd310; bus.doodleY = 32'd87; bus.falling = 1'b0;
    run_tick(2, 1'b1, -1, bn, sn, dn);
    chk("midscan_rise", 32'(bus.hasCollide), 32'd1);
    bus.falling = 1'b1;
    run_tick(2, 1'b0, -1, bn, sn, dn);
    chk("midscan_fall", 32'(bus.hasCollide), 32'd0);

    // Second edge during the scan is dropped and flagged.
    bus.doodleX = 32'd200; bus.doodleY = 32'd0; bus.falling = 1'b1;
    chk("missed_pre", 32'(bus.tickMissed), 32'd0);
    run_tick(-1, 1'b0, 3, bn, sn, dn);
    chk("missed_busy_cycles", 32'(bn), 32'd9);
    chk("missed_collide", 32'(bus.hasCollide), 32'd1);
    chk("missed_flag", 32'(bus.tickMissed), 32'd1);
    repeat (3) @(negedge clk);
    chk("missed_no_queue", 32'(bus.busy), 32'd0);

    // 87 scrolling ticks walk block 1 down from y=87 to 0 and respawn it.
    bus.doodleX = 32'd0; bus.doodleY = 32'd351; bus.falling = 1'b0;
    scroll_tot = 0; bad = 0;
    for (int t = 0; t < 87; t++) begin
      run_tick(-1, 1'b0, -1, bn, sn, dn);
      scroll_tot += sn;
      if (bn != 18 || !dn) bad++;
      if (t == 0) begin
        read_blk(0, rx, ry);
        chk("scr1_b0_y", ry, 32'd699);
        chk("scr1_b0_x_range", 32'(rx < 32'd360), 32'd1);
        read_blk(1, rx, ry);
        chk("scr1_b1_y", ry, 32'd86);
        chk("scr1_b1_x", rx, 32'd300);
      end
    end
    chk("scroll_pulses", 32'(scroll_tot), 32'd87);
    chk("scroll_tick_len", 32'(bad), 32'd0);
    chk("scroll_collide", 32'(bus.hasCollide), 32'd0);
    chk("missed_sticky", 32'(bus.tickMissed), 32'd1);
    read_blk(1, rx, ry);
    chk("scr87_b1_y", ry, 32'd699);
    chk("scr87_b1_x_range", 32'(rx < 32'd360), 32'd1);
    read_blk(0, rx, ry); chk("scr87_b0_y", ry, 32'd613);
    read_blk(2, rx, ry); chk("scr87_b2_y", ry, 32'd87); chk("scr87_b2_x", rx, 32'd60);
    read_blk(7, rx, ry); chk("scr87_b7_y", ry, 32'd522);

    // Reset in the middle of RESPAWN restores the placement table at once.
    @(posedge clk);
    #1 bus.physicsUpdate = 1'b1;
    repeat (2) @(negedge clk);
    bus.physicsUpdate = 1'b0;
    repeat (10) @(negedge clk);
    chk("respawn_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_missed", 32'(bus.tickMissed), 32'd0);
    chk("rst_mid_scroll", 32'(bus.scroll), 32'd0);
    read_blk(0, rx, ry); chk("rst_mid_b0_x", rx, 32'd180); chk("rst_mid_b0_y", ry, 32'd0);
    read_blk(1, rx, ry); chk("rst_mid_b1_x", rx, 32'd300); chk("rst_mid_b1_y", ry, 32'd87);
    read_blk(5, rx, ry); chk("rst_mid_b5_x", rx, 32'd60);  chk("rst_mid_b5_y", ry, 32'd435);
    read_blk(7, rx, ry); chk("rst_mid_b7_x", rx, 32'd300); chk("rst_mid_b7_y", ry, 32'd609);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
